// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-flip-flop chain loader.
// The sequencer FSM states and the width of the final bitstream word live here.
package ccff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ccff_state_e;

    // Valid bits in the last bitstream word of a load; a zero remainder means a full word.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word collector for the bits leaving the chain tail. Presents finished
// words on a valid/ready port and asks the sequencer to stall when it has nowhere to put one.
module ccff_rb_packer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_shift,
    input  logic              i_bit,
    input  logic              i_last,
    input  logic              i_rready,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_stall,
    output logic              o_empty
);

    localparam int IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] r_sreg;
    logic [IDX_W-1:0]  r_idx;
    logic              r_full;
    logic [WORD_W-1:0] r_rdata;
    logic              r_rvalid;

    logic [WORD_W-1:0] w_word;
    logic              w_pending;
    logic              w_free;
    logic              w_complete;

    // Valid/ready: o_rdata is offered while o_rvalid is high and is taken on a clock edge
    // where o_rvalid && i_rready; o_rvalid then drops unless a new word is moved in on that edge.
    always_comb begin
        w_word        = r_sreg;
        w_word[r_idx] = i_bit;
        w_pending     = r_rvalid && !i_rready;
        w_free        = !w_pending;
        w_complete    = !r_full && ((r_idx == IDX_W'(WORD_W - 1)) || i_last);
    end

    // A held full word blocks shifting while the output is pending; it also blocks the
    // final bit, which would otherwise need a second output slot in the same cycle.
    assign o_stall  = r_full && (w_pending || i_last);
    assign o_empty  = !r_full && !r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg   <= '0;
            r_idx    <= '0;
            r_full   <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (r_rvalid && i_rready) begin
                r_rvalid <= 1'b0;
            end
            if (r_full) begin
                if (w_free) begin
                    r_rdata  <= r_sreg;
                    r_rvalid <= 1'b1;
                    r_full   <= 1'b0;
                    r_sreg   <= i_shift ? {{(WORD_W-1){1'b0}}, i_bit} : '0;
                    r_idx    <= i_shift ? IDX_W'(1) : '0;
                end
            end else if (i_shift) begin
                if (w_complete) begin
                    r_idx <= '0;
                    if (w_free) begin
                        r_rdata  <= w_word;
                        r_rvalid <= 1'b1;
                        r_sreg   <= '0;
                    end else begin
                        r_sreg <= w_word;
                        r_full <= 1'b1;
                    end
                end else begin
                    r_sreg <= w_word;
                    r_idx  <= r_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads one ccff chain LSB-first from a word stream while reading back the old contents.
// The FSM and bitstream serialiser live here; readback packing is in ccff_rb_packer.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 6
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_wdata,
    input  logic              cfg_wvalid,
    output logic              cfg_wready,
    output logic [WORD_W-1:0] rb_rdata,
    output logic              rb_rvalid,
    input  logic              rb_rready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt,
    output ccff_state_e       dbg_state
);

    localparam int               LEFT_W    = $clog2(WORD_W + 1);
    localparam int               LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_C    = CNT_W'(WORD_W);

    ccff_state_e       r_state;
    ccff_state_e       w_next;
    logic [WORD_W-1:0] r_sreg;
    logic [LEFT_W-1:0] r_word_left;
    logic [CNT_W-1:0]  r_bit_cnt;

    logic              w_en;
    logic              w_wready;
    logic              w_done;
    logic              w_stall;
    logic              w_rb_empty;
    logic              w_last_bit;
    logic              w_word_end;
    logic [CNT_W-1:0]  w_remaining;

    assign w_remaining = LEN_C - r_bit_cnt;
    assign w_last_bit  = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_IDX);
    assign w_word_end  = (r_word_left == LEFT_W'(1));

    // Handshake: a word is taken on an edge where cfg_wvalid && cfg_wready; ready is only
    // offered in FETCH, so an idle source simply lengthens FETCH.
    always_comb begin
        w_next   = r_state;
        w_wready = 1'b0;
        w_en     = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_wready = 1'b1;
                if (cfg_wvalid) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_en = !w_stall;
                if (w_en && w_word_end) begin
                    w_next = w_last_bit ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (w_rb_empty) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The last word is trimmed to the bits the chain still needs; its spare upper bits never shift.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_sreg      <= '0;
            r_word_left <= '0;
            r_bit_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_bit_cnt <= '0;
            end
            if (r_state == ST_FETCH && cfg_wvalid) begin
                r_sreg      <= cfg_wdata;
                r_word_left <= (w_remaining <= WORD_C) ? LEFT_W'(LAST_BITS) : LEFT_W'(WORD_W);
            end
            if (w_en) begin
                r_sreg      <= r_sreg >> 1;
                r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                r_word_left <= r_word_left - LEFT_W'(1);
            end
        end
    end

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_rb_packer (
        .clk      (prog_clk),
        .rst_n    (pReset),
        .i_shift  (w_en),
        .i_bit    (ccff_tail),
        .i_last   (w_last_bit),
        .i_rready (rb_rready),
        .o_rdata  (rb_rdata),
        .o_rvalid (rb_rvalid),
        .o_stall  (w_stall),
        .o_empty  (w_rb_empty)
    );

    assign cfg_wready = w_wready;
    assign ccff_en    = w_en;
    assign done       = w_done;
    assign busy       = (r_state != ST_IDLE);
    assign bit_cnt    = r_bit_cnt;
    assign ccff_head  = (r_state == ST_SHIFT) && r_sreg[0];
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a chain model on the serial pins, a bit-queue reference of
// the chain contents, and a readback scoreboard fed by the load driver.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int CHAIN_LEN = 36;
  localparam int WORD_W    = 8;
  localparam int CNT_W     = 6;
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int TIMEOUT   = 3000;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic [WORD_W-1:0] cfg_wdata;
  logic              cfg_wvalid;
  logic              cfg_wready;
  logic [WORD_W-1:0] rb_rdata;
  logic              rb_rvalid;
  logic              rb_rready;
  logic              ccff_head;
  logic              ccff_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_cnt;
  ccff_state_e       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_total = 0;
  int rr_mode = 0;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic [WORD_W-1:0]    exp_q[$];
  bit                   exp_chain[$];
  logic [WORD_W-1:0]    words[NW];

  ccff_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .CNT_W     (CNT_W)
  ) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .start      (start),
    .cfg_wdata  (cfg_wdata),
    .cfg_wvalid (cfg_wvalid),
    .cfg_wready (cfg_wready),
    .rb_rdata   (rb_rdata),
    .rb_rvalid  (rb_rvalid),
    .rb_rready  (rb_rready),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done),
    .bit_cnt    (bit_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset-independent infrastructure
  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // physical chain: shifts head in, tail out, only on enabled edges
  assign ccff_tail = chain[CHAIN_LEN-1];
  always @(posedge prog_clk) begin
    if (ccff_en) begin
      chain    <= {chain[CHAIN_LEN-2:0], ccff_head};
      en_total <= en_total + 1;
    end
  end

  // readback consumer: 0 = always ready, 1 = random, 2 = held off
  initial begin
    rb_rready = 1'b1;
    forever begin
      @(posedge prog_clk);
      #2;
      case (rr_mode)
        0:       rb_rready = 1'b1;
        1:       rb_rready = 1'($urandom_range(0, 1));
        default: rb_rready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge prog_clk) begin
    if (pReset === 1'b1 && rb_rvalid === 1'b1 && rb_rready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rb_unexpected_word", 64'(rb_rdata), 64'hDEAD);
      end else begin
        chk("rb_word", 64'(rb_rdata), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_wready"}, 64'(cfg_wready), 64'd0);
    chk({tag, "_rvalid"}, 64'(rb_rvalid), 64'd0);
    chk({tag, "_rdata"}, 64'(rb_rdata), 64'd0);
    chk({tag, "_head"}, 64'(ccff_head), 64'd0);
    chk({tag, "_en"}, 64'(ccff_en), 64'd0);
    chk({tag, "_bitcnt"}, 64'(bit_cnt), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // One chain load. abort_at >= 0 pulls reset once bit_cnt reaches it; mid_start >= 0
  // pulses start on that loop cycle; exp_lat > 0 checks start-to-done latency.
  task automatic do_load(input int gap, input bit do_stall, input int abort_at,
                         input int mid_start, input int exp_lat);
    bit                   s[CHAIN_LEN];
    logic [WORD_W-1:0]    w;
    logic [CHAIN_LEN-1:0] expv;
    int nbits, nout, idx, k, gap_cnt, stall_ctr, t0, lat, en0;
    int gap_cycles, gap_en_hits, stall_bad, stall_bcnt;
    bit got_done, aborted, stall_started, hs;

    nbits = (abort_at >= 0) ? abort_at : CHAIN_LEN;
    nout  = (abort_at >= 0) ? nbits / WORD_W : NW;
    for (int i = 0; i < CHAIN_LEN; i++) s[i] = words[i / WORD_W][i % WORD_W];
    // readback = the bits that leave the tail, oldest first, packed LSB-first
    for (int j = 0; j < nout; j++) begin
      w = '0;
      for (int b = 0; b < WORD_W; b++) begin
        idx = j * WORD_W + b;
        if (idx < nbits) w[b] = exp_chain[idx];
      end
      exp_q.push_back(w);
    end
    for (int i = 0; i < nbits; i++) void'(exp_chain.pop_front());
    for (int i = 0; i < nbits; i++) exp_chain.push_back(s[i]);

    k = 0; gap_cnt = 0; stall_ctr = 0; lat = -1;
    gap_cycles = 0; gap_en_hits = 0; stall_bad = 0; stall_bcnt = -1;
    got_done = 0; aborted = 0; stall_started = 0;
    en0 = en_total;

    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    t0 = cyc;
    start = 1'b0;
    cfg_wvalid = 1'b1;
    cfg_wdata = words[0];

    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge prog_clk);
      hs = cfg_wvalid && cfg_wready;
      if (cfg_wready && !cfg_wvalid && k < NW && gap_cnt > 0) begin
        gap_cnt--;
        gap_cycles++;
        if (ccff_en) gap_en_hits++;
      end
      if (stall_ctr > 0) begin
        stall_ctr--;
        if (stall_ctr < 10 && (ccff_en || bit_cnt != CNT_W'(16))) stall_bad++;
        if (stall_ctr == 0) begin
          stall_bcnt = int'(bit_cnt);
          rr_mode = 0;
        end
      end
      if (done) begin
        lat = cyc - t0;
        got_done = 1;
      end
      @(posedge prog_clk); #1;
      start = (c == mid_start) ? 1'b1 : 1'b0;
      if (got_done) break;
      if (abort_at >= 0 && bit_cnt == CNT_W'(abort_at)) begin
        pReset = 1'b0;
        aborted = 1;
        break;
      end
      if (do_stall && !stall_started && bit_cnt == CNT_W'(8)) begin
        stall_started = 1;
        rr_mode = 2;
        stall_ctr = 20;
      end
      if (hs) begin
        k++;
        if (k < NW && gap == 0) begin
          cfg_wdata = words[k];
        end else begin
          cfg_wvalid = 1'b0;
          gap_cnt = gap;
        end
      end else if (!cfg_wvalid && k < NW && gap_cnt == 0) begin
        cfg_wvalid = 1'b1;
        cfg_wdata = words[k];
      end
    end
    start = 1'b0;
    cfg_wvalid = 1'b0;

    for (int i = 0; i < CHAIN_LEN; i++) expv[CHAIN_LEN-1-i] = exp_chain[i];
    if (aborted) begin
      @(negedge prog_clk);
      check_outputs_zero("abort");
      chk("abort_shifted_bits", 64'(en_total - en0), 64'(abort_at));
      chk("abort_chain", 64'(chain), 64'(expv));
      chk("abort_rb_left", 64'(exp_q.size()), 64'd0);
      @(posedge prog_clk); #1;
      pReset = 1'b1;
    end else begin
      chk("load_done_seen", 64'(got_done), 64'd1);
      chk("enabled_edges", 64'(en_total - en0), 64'(CHAIN_LEN));
      chk("chain_contents", 64'(chain), 64'(expv));
      chk("bit_cnt_final", 64'(bit_cnt), 64'(CHAIN_LEN));
      chk("rb_all_consumed", 64'(exp_q.size()), 64'd0);
      chk("idle_after_done", 64'(busy), 64'd0);
      if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
      if (gap > 0) begin
        chk("gap_en_low", 64'(gap_en_hits), 64'd0);
        chk("gap_cycles", 64'(gap_cycles), 64'(gap * (NW - 1)));
      end
      if (do_stall) begin
        chk("stall_en_low", 64'(stall_bad), 64'd0);
        chk("stall_bit_cnt", 64'(stall_bcnt), 64'd16);
      end
    end
  endtask

  task automatic set_test1_words();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
  endtask

  task automatic set_random_words();
    for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom_range(0, 255));
  endtask

  initial begin
    pReset = 1'b0;
    start = 1'b0;
    cfg_wvalid = 1'b0;
    cfg_wdata = '0;
    for (int i = 0; i < CHAIN_LEN; i++) exp_chain.push_back(1'b0);

    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check_outputs_zero("reset");
    @(posedge prog_clk); #1;
    pReset = 1'b1;

    // 1: load over an all-zero chain, back-to-back words
    set_test1_words();
    do_load(0, 0, -1, -1, CHAIN_LEN + NW + 2);

    // 2: same stream again, readback returns it with the unused nibble zeroed
    do_load(0, 0, -1, -1, CHAIN_LEN + NW + 2);

    // 3: readback held off during the second word
    set_random_words();
    do_load(0, 1, -1, -1, -1);

    // 4: source gaps of 3 FETCH cycles between words
    set_test1_words();
    do_load(3, 0, -1, -1, CHAIN_LEN + NW + 2 + 3 * (NW - 1));

    // 5: reset in the middle of a load, then a clean load
    set_random_words();
    do_load(0, 0, 20, -1, -1);
    set_random_words();
    do_load(0, 0, -1, -1, CHAIN_LEN + NW + 2);

    // 6: cfg_wvalid while idle, and start pulsed while busy
    @(posedge prog_clk); #1;
    cfg_wvalid = 1'b1;
    cfg_wdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      chk("idle_wready", 64'(cfg_wready), 64'd0);
      chk("idle_en", 64'(ccff_en), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    @(posedge prog_clk); #1;
    cfg_wvalid = 1'b0;
    set_random_words();
    do_load(0, 0, -1, 10, CHAIN_LEN + NW + 2);

    // random loads with a random readback consumer and random source gaps
    rr_mode = 1;
    for (int r = 0; r < 4; r++) begin
      set_random_words();
      do_load(int'($urandom_range(0, 2)), 0, -1, -1, -1);
    end
    rr_mode = 0;

    repeat (4) @(posedge prog_clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
